// File: rtl/eco32_core_lsu_pkg.sv
// rtl/eco32_core_lsu_pkg.sv - shared LSU types, constants and helpers
package eco32_core_lsu_pkg;

   // Pointer value meaning "no entries"; cast to the pointer width at use.
   localparam int SRL_EMPTY = -1;

   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [29:0] addr;
      logic [31:0] wdata;
   } dcm_req_t;

   localparam int DCM_REQ_W = $bits(dcm_req_t);

   typedef logic [DCM_REQ_W-1:0] dcm_req_bits_t;

   function automatic dcm_req_bits_t dcm_req_pack(input dcm_req_t r);
      return dcm_req_bits_t'(r);
   endfunction

   function automatic dcm_req_t dcm_req_unpack(input dcm_req_bits_t b);
      return dcm_req_t'(b);
   endfunction

endpackage

// File: rtl/eco32_core_lsu_srl_fifo_if.sv
// rtl/eco32_core_lsu_srl_fifo_if.sv - push/pop handshake bundle for the SRL FIFO
interface eco32_core_lsu_srl_fifo_if
   import eco32_core_lsu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
);
   logic                                       i_flush;
   logic                                       i_stb;
   logic [WIDTH-1:0]                           i_data;
   logic                                       i_rdy;
   logic                                       o_stb;
   logic [WIDTH-1:0]                           o_data;
   logic                                       o_ack;
   logic [level_width(1 << DEPTH_LOG2)-1:0]    o_level;
   logic                                       o_ovf;
   logic                                       o_udf;

   modport master (
      output i_flush, i_stb, i_data, o_ack,
      input  i_rdy, o_stb, o_data, o_level, o_ovf, o_udf
   );

   modport slave (
      input  i_flush, i_stb, i_data, o_ack,
      output i_rdy, o_stb, o_data, o_level, o_ovf, o_udf
   );
endinterface

// File: rtl/eco32_core_lsu_srl_line.sv
// rtl/eco32_core_lsu_srl_line.sv - 1-bit addressable shift register, no reset
module eco32_core_lsu_srl_line
   import eco32_core_lsu_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  shift_en,
   input  logic                  din,
   input  logic [DEPTH_LOG2-1:0] addr,
   output logic                  dout
);
   localparam int D = 1 << DEPTH_LOG2;

   logic [D-1:0] sr;

   always_ff @(posedge clk) begin
      if (shift_en) sr <= {sr[D-2:0], din};
   end

   assign dout = sr[addr];
endmodule

// File: rtl/eco32_core_lsu_srl_fifo.sv
// rtl/eco32_core_lsu_srl_fifo.sv - shift-register FIFO with guarded push/pop and registered almost-full
module eco32_core_lsu_srl_fifo
   import eco32_core_lsu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_SLACK   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   eco32_core_lsu_srl_fifo_if.slave      bus
);
   localparam int D  = 1 << DEPTH_LOG2;
   localparam int PW = level_width(D);

   localparam logic [PW-1:0] DEPTH_V = PW'(D);
   localparam logic [PW-1:0] RDY_MAX = PW'(D - AF_SLACK);
   localparam logic [PW-1:0] EMPTY   = PW'(SRL_EMPTY);

   logic [PW-1:0]    sel_q;
   logic [PW-1:0]    sel_d;
   logic [PW-1:0]    count;
   logic [PW-1:0]    count_next;
   logic             full;
   logic             push_ok;
   logic             pop_ok;
   logic             shift_en;
   logic             rdy_q;
   logic             ovf_q;
   logic             udf_q;
   logic [WIDTH-1:0] head;

   // sel holds count-1, so the head entry is addressed directly by the pointer.
   assign count    = sel_q + 1'b1;
   assign full     = (count == DEPTH_V);
   assign push_ok  = bus.i_stb & ~full;
   assign pop_ok   = bus.o_ack & ~sel_q[PW-1];
   assign shift_en = push_ok & ~bus.i_flush;

   always_comb begin
      sel_d = sel_q;
      if (bus.i_flush)
         sel_d = EMPTY;
      else if (push_ok && !pop_ok)
         sel_d = sel_q + 1'b1;
      else if (pop_ok && !push_ok)
         sel_d = sel_q - 1'b1;
   end

   assign count_next = sel_d + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= EMPTY;
         rdy_q <= 1'b0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
         rdy_q <= (count_next <= RDY_MAX);
         if (bus.i_flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            if (bus.i_stb && full)          ovf_q <= 1'b1;
            if (bus.o_ack && sel_q[PW-1])   udf_q <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_line
      eco32_core_lsu_srl_line #(
         .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_line (
         .clk      (clk),
         .shift_en (shift_en),
         .din      (bus.i_data[b]),
         .addr     (sel_q[DEPTH_LOG2-1:0]),
         .dout     (head[b])
      );
   end

   assign bus.i_rdy   = rdy_q;
   assign bus.o_stb   = ~sel_q[PW-1];
   assign bus.o_data  = head;
   assign bus.o_level = count;
   assign bus.o_ovf   = ovf_q;
   assign bus.o_udf   = udf_q;
endmodule
